// File: rtl/fp_align_add.sv
// fp_align_add: front half of a single-precision adder.
// Unpacks two IEEE754 operands, orders them by magnitude, aligns the smaller
// mantissa one bit per cycle, then adds or subtracts the mantissas.
// Produces the larger exponent and a 25-bit unnormalised fraction for the
// downstream normalisation stage.
module fp_align_add #(
   parameter int MAX_SHIFT = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign_out,
   output logic [7:0]  exp_max,
   output logic [24:0] fraction_25
);

   localparam int CNT_W = $clog2(MAX_SHIFT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SWAP  = 3'd1,
      ALIGN = 3'd2,
      ADD   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state_r;
   logic [31:0]        a_r;
   logic [31:0]        b_r;
   logic               sign_l_r;
   logic               sign_s_r;
   logic [23:0]        mant_l_r;
   logic [23:0]        mant_s_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic               sign_out_r;
   logic [7:0]         exp_max_r;
   logic [24:0]        fraction_r;

   logic [7:0]         exp_a_s;
   logic [7:0]         exp_b_s;
   logic [23:0]        mant_a_s;
   logic [23:0]        mant_b_s;
   logic               a_is_l_s;
   logic [7:0]         exp_l_s;
   logic [7:0]         exp_sm_s;
   logic [7:0]         exp_diff_s;
   logic [CNT_W-1:0]   cnt_init_s;

   logic [24:0]        sum_s;
   logic [24:0]        dif_s;
   logic [24:0]        res_s;
   logic               res_sign_s;

   // Unpack captured operands, pick the larger one and derive the capped shift count.
   always_comb begin
      exp_a_s    = a_r[30:23];
      exp_b_s    = b_r[30:23];
      mant_a_s   = {(exp_a_s != 8'd0), a_r[22:0]};
      mant_b_s   = {(exp_b_s != 8'd0), b_r[22:0]};
      // On an exact tie A is treated as the larger operand.
      a_is_l_s   = ({exp_a_s, mant_a_s} >= {exp_b_s, mant_b_s});
      exp_l_s    = 8'd0;
      exp_sm_s   = 8'd0;
      if (a_is_l_s) begin
         exp_l_s  = exp_a_s;
         exp_sm_s = exp_b_s;
      end else begin
         exp_l_s  = exp_b_s;
         exp_sm_s = exp_a_s;
      end
      exp_diff_s = exp_l_s - exp_sm_s;
      cnt_init_s = '0;
      if (exp_diff_s > 8'(MAX_SHIFT)) begin
         cnt_init_s = CNT_W'(MAX_SHIFT);
      end else begin
         cnt_init_s = exp_diff_s[CNT_W-1:0];
      end
   end

   // Mantissa add/subtract; a zero difference always yields a positive zero.
   always_comb begin
      sum_s      = {1'b0, mant_l_r} + {1'b0, mant_s_r};
      dif_s      = {1'b0, mant_l_r} - {1'b0, mant_s_r};
      res_s      = 25'd0;
      res_sign_s = 1'b0;
      if (sign_l_r != sign_s_r) begin
         res_s = dif_s;
         if (dif_s == 25'd0) begin
            res_sign_s = 1'b0;
         end else begin
            res_sign_s = sign_l_r;
         end
      end else begin
         res_s      = sum_s;
         res_sign_s = sign_l_r;
      end
   end

   // Control FSM with all datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         a_r         <= 32'd0;
         b_r         <= 32'd0;
         sign_l_r    <= 1'b0;
         sign_s_r    <= 1'b0;
         mant_l_r    <= 24'd0;
         mant_s_r    <= 24'd0;
         cnt_r       <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         sign_out_r  <= 1'b0;
         exp_max_r   <= 8'd0;
         fraction_r  <= 25'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r        <= a_in;
                  b_r        <= b_in;
                  in_ready_r <= 1'b0;
                  state_r    <= SWAP;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            SWAP: begin
               if (a_is_l_s) begin
                  sign_l_r <= a_r[31];
                  sign_s_r <= b_r[31];
                  mant_l_r <= mant_a_s;
                  mant_s_r <= mant_b_s;
               end else begin
                  sign_l_r <= b_r[31];
                  sign_s_r <= a_r[31];
                  mant_l_r <= mant_b_s;
                  mant_s_r <= mant_a_s;
               end
               exp_max_r <= exp_l_s;
               cnt_r     <= cnt_init_s;
               if (cnt_init_s != '0) begin
                  state_r <= ALIGN;
               end else begin
                  state_r <= ADD;
               end
            end
            ALIGN: begin
               // Truncating shift: bits falling off the bottom are discarded.
               mant_s_r <= mant_s_r >> 1;
               cnt_r    <= cnt_r - CNT_W'(1);
               if (cnt_r == CNT_W'(1)) begin
                  state_r <= ADD;
               end else begin
                  state_r <= ALIGN;
               end
            end
            ADD: begin
               fraction_r <= res_s;
               sign_out_r <= res_sign_s;
               state_r    <= DONE;
            end
            DONE: begin
               // First DONE cycle raises out_valid; the handshake is only
               // taken once the result is visibly presented.
               if (out_valid_r) begin
                  if (out_ready) begin
                     out_valid_r <= 1'b0;
                     in_ready_r  <= 1'b1;
                     state_r     <= IDLE;
                  end else begin
                     out_valid_r <= 1'b1;
                  end
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign sign_out    = sign_out_r;
   assign exp_max     = exp_max_r;
   assign fraction_25 = fraction_r;

endmodule

// File: doc/fp_align_add.md
Name: fp_align_add

Overview:
- Front half of the IEEE754 single-precision adder. Accepts two packed 32-bit operands through a valid/ready handshake.
- Unpacks both operands, orders them by magnitude, and aligns the smaller mantissa with an iterative one-bit-per-cycle right shifter. It then adds or subtracts the mantissas.
- Outputs exp_max and the 25-bit unnormalised fraction_25 that the downstream Norm stage consumes.

Parameters:
- MAX_SHIFT, 24: alignment shift cap; a mantissa shifted 24 places is always zero.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands a_in/b_in valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a_in  input  32  IEEE754 operand A
- b_in  input  32  IEEE754 operand B
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  downstream accepts result
- sign_out  output  1  sign of result
- exp_max  output  8  larger operand exponent
- fraction_25  output  25  bit24 = carry, bit23 = hidden bit, [22:0] = fraction

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state goes to IDLE; in_ready=1, out_valid=0, sign_out=0, exp_max=0, fraction_25=0.
  - Shift counter and operand registers are cleared.
  - Reset asserted in any state aborts the operation in flight; no result is produced.
- Unpack:
  - hidden bit = 1 if exponent != 0, else 0 (denormals are treated as 0.fraction at their coded exponent).
  - Mantissa = {hidden, frac[22:0]}, 24 bits.
  - NaN/Inf are not special-cased: exponent 255 is treated as an ordinary exponent.
- FSM states: IDLE, SWAP, ALIGN, ADD, DONE.
- IDLE: in_ready=1. On in_valid at an edge, capture a_in/b_in and go to SWAP.
- SWAP (1 cycle):
  - Compare {exp, mantissa} of the operands. The larger becomes L; on a tie, A is L.
  - exp_max <= exp_L.
  - cnt <= min(exp_L - exp_S, MAX_SHIFT).
  - Next state is ALIGN if cnt != 0, else ADD.
- ALIGN:
  - Each cycle: mant_S >>= 1 (zero fill, no guard/sticky; truncation) and cnt -= 1.
  - Go to ADD when cnt reaches 0. This takes exactly n cycles, where n = min(diff, 24).
- ADD (1 cycle):
  - Same signs: fraction_25 <= {1'b0, mant_L} + {1'b0, mant_S}, and sign_out <= sign_L.
  - Different signs: fraction_25 <= {1'b0, mant_L} - {1'b0, mant_S}. This never underflows, because L >= S.
    - sign_out <= sign_L.
    - If the difference is zero, sign_out is forced to 0.
  - Next state is DONE.
- DONE:
  - out_valid=1; outputs are stable.
  - On out_ready at an edge, go to IDLE; out_valid drops next cycle.
  - If out_ready stays low, the block holds indefinitely.
- in_ready is low in SWAP, ALIGN, ADD and DONE. in_valid in those states is ignored and not queued.
- Latency: the accept edge is edge 0; out_valid is first high n+3 cycles later. Throughput is one operation at a time.
- A new operation may be accepted no earlier than the cycle after the DONE handshake edge.
- Exponent difference is computed as an unsigned 8-bit value exp_L - exp_S (always >= 0) and saturated to 24 before loading cnt.

Test Plan:
- 0x3F800000 + 0x3F800000 (1.0 + 1.0) -> exp_max=127, fraction_25=25'h1000000, sign_out=0, out_valid 3 cycles after accept.
- 0x3FC00000 + 0x3F400000 (1.5 + 0.75) -> one ALIGN cycle, exp_max=127, fraction_25=25'h1200000, latency 4.
- Effective subtraction and swap:
  - 0x3F800000 + 0xBF000000 -> fraction_25=25'h0400000, exp_max=127, sign_out=0.
  - 0x3F000000 + 0xBF800000 -> same fraction, sign_out=1.
  - 0x3F800000 + 0xBF800000 -> fraction_25=0, sign_out=0, exp_max=127.
- Shift saturation:
  - 0x4B800000 + 0x3F800000 (diff 24) -> fraction_25=25'h0800000, exp_max=151, latency 27.
  - 0x71800000 + 0x3F800000 (diff 100) -> fraction_25=25'h0800000, exp_max=227, latency 27 (capped).
- Handshake: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, and a new in_valid is ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst during the ALIGN of the diff-24 case -> next cycle state IDLE, out_valid=0, all outputs 0. A following 1.0+1.0 then completes normally with latency 3.
